// File: rtl/quant_output_packer.sv
// quant_output_packer: adds the output zero point, clamps (optional ReLU) to
// int8 and packs four results little-endian into 32-bit feature-map words.
// It also sequences the requantizer, pulsing q_rst between elements because
// the requantizer does not restart on its own.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start, requantizer held in reset
// WAIT    | requantizer running; capture once q_ok has been seen low then high
// CLAMP   | zero-point add and saturation of the captured value
// PACK    | place byte into its lane, advance the element counter
// WRITE   | one-cycle RAM write of the packed word
// RESTART | one-cycle requantizer reset before the next element
// DONE    | map complete, requantizer held in reset, done high
module quant_output_packer #(
    parameter int ZERO_POINT = 0,
    parameter int RELU       = 1,
    parameter int ACT_MIN    = -128,
    parameter int ACT_MAX    = 127,
    parameter int NUM_OUT    = 676,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [8:0]        q_data,
    input  logic              q_ok,
    output logic              q_rst,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              busy,
    output logic              done
);

    // Counter must hold NUM_OUT itself and always expose a 2-bit lane.
    localparam int CNT_W = ($clog2(NUM_OUT + 1) < 2) ? 2 : $clog2(NUM_OUT + 1);

    localparam logic signed [9:0] ZP10  = 10'(ZERO_POINT);
    localparam logic signed [9:0] MIN10 = 10'(ACT_MIN);
    localparam logic signed [9:0] MAX10 = 10'(ACT_MAX);
    localparam logic signed [9:0] LO10  = (RELU != 0) ? ZP10 : MIN10;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CLAMP,
        PACK,
        WRITE,
        RESTART,
        DONE
    } state_t;

    state_t             state;
    logic               armed;
    logic [8:0]         q_cap;
    logic [7:0]         v_q;
    logic [CNT_W-1:0]   elem_cnt;
    logic [31:0]        pack_q;
    logic [3:0]         mask_q;
    logic               map_end;
    logic               wr_pend;

    logic [1:0]         lane;
    logic signed [9:0]  sum10;
    logic signed [9:0]  floor10;
    logic signed [9:0]  clamp10;

    assign lane = elem_cnt[1:0];

    // Zero-point add in 10 bits (cannot overflow), then max against the lower
    // bound followed by min against the upper bound.
    always_comb begin
        sum10   = $signed({q_cap[8], q_cap}) + ZP10;
        floor10 = (sum10 < LO10) ? LO10 : sum10;
        clamp10 = (floor10 > MAX10) ? MAX10 : floor10;
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            armed     <= 1'b0;
            q_cap     <= '0;
            v_q       <= '0;
            elem_cnt  <= '0;
            pack_q    <= '0;
            mask_q    <= '0;
            map_end   <= 1'b0;
            wr_pend   <= 1'b0;
            q_rst     <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= WAIT;
                        q_rst    <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        armed    <= 1'b0;
                        elem_cnt <= '0;
                        pack_q   <= '0;
                        mask_q   <= '0;
                        map_end  <= 1'b0;
                        wr_pend  <= 1'b0;
                        mem_addr <= '0;
                    end
                end
                WAIT: begin
                    // A q_ok still high from the previous element is ignored
                    // until it has been seen low at least once.
                    if (!q_ok) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        q_cap <= q_data;
                        state <= CLAMP;
                    end
                end
                CLAMP: begin
                    v_q   <= clamp10[7:0];
                    state <= PACK;
                end
                PACK: begin
                    pack_q[{lane, 3'b000} +: 8] <= v_q;
                    mask_q[lane]                <= 1'b1;
                    elem_cnt                    <= elem_cnt + CNT_W'(1);
                    map_end <= (elem_cnt == CNT_W'(NUM_OUT - 1));
                    if (lane == 2'd3 || elem_cnt == CNT_W'(NUM_OUT - 1)) begin
                        state <= WRITE;
                    end else begin
                        state <= RESTART;
                        q_rst <= 1'b1;
                    end
                end
                WRITE: begin
                    mem_we    <= 1'b1;
                    mem_wdata <= pack_q;
                    mem_be    <= mask_q;
                    pack_q    <= '0;
                    mask_q    <= '0;
                    q_rst     <= 1'b1;
                    if (map_end) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state   <= RESTART;
                        wr_pend <= 1'b1;
                    end
                end
                RESTART: begin
                    // The address only advances once a word has gone out and
                    // more elements follow, so it never passes the last word.
                    if (wr_pend) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                    wr_pend <= 1'b0;
                    armed   <= 1'b0;
                    q_rst   <= 1'b0;
                    state   <= WAIT;
                end
                default: begin
                    state <= IDLE;
                    q_rst <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quant_output_packer.sv
// Bench for quant_output_packer: four instances with different zero point,
// ReLU and map-size settings, a reactive requantizer model, and a write
// scoreboard filled when each map is launched.
module tb_quant_output_packer;

    typedef struct {
        int          inst;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start     [4];
    logic [8:0]  q_data    [4];
    logic        q_ok      [4];
    logic        q_rst     [4];
    logic        mem_we    [4];
    logic [9:0]  mem_addr  [4];
    logic [31:0] mem_wdata [4];
    logic [3:0]  mem_be    [4];
    logic        busy      [4];
    logic        done      [4];

    int zp_cfg   [4] = '{0, 0, 10, 0};
    int relu_cfg [4] = '{0, 1, 0, 0};

    exp_t sb[$];
    int   stim[8];
    int   n_run  = 0;
    int   n_fail = 0;
    int   rise   [4] = '{0, 0, 0, 0};
    bit   qrst_prev [4] = '{0, 0, 0, 0};
    int   r0;

    quant_output_packer #(.ZERO_POINT(0), .RELU(0), .NUM_OUT(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .q_data(q_data[0]), .q_ok(q_ok[0]),
        .q_rst(q_rst[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_be(mem_be[0]), .busy(busy[0]), .done(done[0]));
    quant_output_packer #(.ZERO_POINT(0), .RELU(1), .NUM_OUT(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .q_data(q_data[1]), .q_ok(q_ok[1]),
        .q_rst(q_rst[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_be(mem_be[1]), .busy(busy[1]), .done(done[1]));
    quant_output_packer #(.ZERO_POINT(10), .RELU(0), .NUM_OUT(4)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .q_data(q_data[2]), .q_ok(q_ok[2]),
        .q_rst(q_rst[2]), .mem_we(mem_we[2]), .mem_addr(mem_addr[2]),
        .mem_wdata(mem_wdata[2]), .mem_be(mem_be[2]), .busy(busy[2]), .done(done[2]));
    quant_output_packer #(.ZERO_POINT(0), .RELU(0), .NUM_OUT(6)) u_dut3 (
        .clk(clk), .rst(rst), .start(start[3]), .q_data(q_data[3]), .q_ok(q_ok[3]),
        .q_rst(q_rst[3]), .mem_we(mem_we[3]), .mem_addr(mem_addr[3]),
        .mem_wdata(mem_wdata[3]), .mem_be(mem_be[3]), .busy(busy[3]), .done(done[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_run++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
        end
    endtask

    // Reference byte: zero-point add, lower bound (ReLU or int8 min), int8 max.
    function automatic logic [7:0] model(input int k, input int x);
        int s;
        int lo;
        s  = x + zp_cfg[k];
        lo = (relu_cfg[k] != 0) ? zp_cfg[k] : -128;
        if (s < lo)  s = lo;
        if (s > 127) s = 127;
        return 8'(s);
    endfunction

    // Scoreboard check of every RAM write plus q_rst rise counting.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (q_rst[k] && !qrst_prev[k]) rise[k]++;
            qrst_prev[k] = q_rst[k];
            if (!rst && mem_we[k]) begin
                if (sb.size() == 0) begin
                    chk("spurious_we", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wr_inst", 32'(k), 32'(e.inst));
                    chk("wr_addr", 32'(mem_addr[k]), 32'(e.addr));
                    chk("wr_data", mem_wdata[k], e.data);
                    chk("wr_be", 32'(mem_be[k]), 32'(e.be));
                end
            end
        end
    end

    task automatic wait_qrst(input int k, input logic lvl);
        for (int i = 0; i < 200; i++) begin
            if (q_rst[k] == lvl) return;
            @(negedge clk);
        end
        chk("qrst_timeout", 32'(q_rst[k]), 32'(lvl));
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    // Requantizer model: present one result after the packer releases q_rst,
    // drop q_ok when q_rst is reasserted unless asked to hold it (stale level).
    task automatic feed(input int k, input int val, input bit hold);
        wait_qrst(k, 1'b0);
        if (q_ok[k]) begin
            repeat (3) @(negedge clk);
            q_ok[k] = 1'b0;
        end
        @(negedge clk);
        q_data[k] = 9'(val);
        q_ok[k]   = 1'b1;
        wait_qrst(k, 1'b1);
        if (!hold) q_ok[k] = 1'b0;
    endtask

    task automatic run_map(input int k, input int n, input int hold_idx, input int poke_idx);
        logic [31:0] word;
        logic [3:0]  be;
        word = '0;
        be   = '0;
        for (int i = 0; i < n; i++) begin
            word[8*(i%4) +: 8] = model(k, stim[i]);
            be[i%4] = 1'b1;
            if ((i % 4) == 3 || i == n - 1) begin
                sb.push_back('{k, 10'(i / 4), word, be});
                word = '0;
                be   = '0;
            end
        end
        pulse_start(k);
        for (int i = 0; i < n; i++) begin
            feed(k, stim[i], i == hold_idx);
            if (i == 0) chk("busy_run", 32'(busy[k]), 32'd1);
            if (i == poke_idx) pulse_start(k);
        end
        @(negedge clk);
        chk("done_end", 32'(done[k]), 32'd1);
        chk("busy_end", 32'(busy[k]), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_qrst"},  32'(q_rst[0]), 32'd1);
        chk({tag, "_we"},    32'(mem_we[0]), 32'd0);
        chk({tag, "_addr"},  32'(mem_addr[0]), 32'd0);
        chk({tag, "_wdata"}, mem_wdata[0], 32'd0);
        chk({tag, "_be"},    32'(mem_be[0]), 32'd0);
        chk({tag, "_busy"},  32'(busy[0]), 32'd0);
        chk({tag, "_done"},  32'(done[0]), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            start[k]  = 1'b0;
            q_ok[k]   = 1'b0;
            q_data[k] = '0;
        end
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);

        // Saturation, ReLU off: 0x7F7FFD05, 3 RESTART pulses + DONE level.
        stim = '{5, -3, 130, 127, 0, 0, 0, 0};
        r0 = rise[0];
        run_map(0, 4, -1, -1);
        chk("qrst_pulses", 32'(rise[0] - r0), 32'd4);
        chk("addr_last", 32'(mem_addr[0]), 32'd0);

        // Same stimulus with ReLU: 0x7F7F0005.
        run_map(1, 4, -1, -1);

        // Zero point 10: 0x0A80807F.
        stim = '{120, -200, -138, 0, 0, 0, 0, 0};
        run_map(2, 4, -1, -1);

        // Partial last word; a start pulse mid-map must be ignored.
        stim = '{1, 1, 1, 1, 1, 1, 0, 0};
        run_map(3, 6, -1, 1);
        chk("addr_last6", 32'(mem_addr[3]), 32'd1);

        // Restart from DONE with a stale q_ok held into the next WAIT.
        stim = '{9, 7, 3, 4, 0, 0, 0, 0};
        run_map(0, 4, 0, -1);

        // Abort after two captured elements: nothing written, clean restart.
        pulse_start(0);
        feed(0, 11, 1'b0);
        feed(0, 22, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("abort");
        rst = 1'b0;
        @(negedge clk);
        stim = '{1, 2, 3, 4, 0, 0, 0, 0};
        run_map(0, 4, -1, -1);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/quant_output_packer.md
Name: quant_output_packer

Overview:
- Downstream stage of the per-pixel requantizer.
- Consumes one signed 9-bit requantized value per quantizer run.
- Adds the output zero point, optionally applies ReLU, saturates to int8, and packs 4 results little-endian into 32-bit words written to the output feature-map RAM.
- Sequences the requantizer by pulsing its reset between elements, since the requantizer FSM does not self-restart.

Parameters:
ZERO_POINT, 0, signed 9-bit output zero point added before clamp
RELU, 1, 1 = lower clamp bound is ZERO_POINT; 0 = lower bound is ACT_MIN
ACT_MIN, -128, signed saturation lower bound
ACT_MAX, 127, signed saturation upper bound
NUM_OUT, 676, elements per feature map (26x26)
ADDR_W, 10, word address width

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  reset, asynchronous, active-high
start  in  1  1-cycle pulse; begins a feature map
q_data  in  9  signed requantized value from the requantizer
q_ok  in  1  requantizer result-valid level; stays high until the requantizer is reset
q_rst  out  1  reset to the requantizer; high = hold it in reset
mem_we  out  1  1-cycle write strobe
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  packed bytes; element 4k+i in bits [8i+7:8i]
mem_be  out  4  byte enables for valid lanes
busy  out  1  high outside IDLE/DONE
done  out  1  level, high in DONE until next start

Behaviour:
- Reset values: state IDLE; q_rst=1; mem_we=0; mem_addr=0; mem_wdata=0; mem_be=0; busy=0; done=0. Element counter, lane, and pack register are cleared.
- rst mid-map aborts immediately. No partial word is written.
- FSM states: IDLE, WAIT, CLAMP, PACK, WRITE, RESTART, DONE.
- IDLE: q_rst=1. On start, clear counters and mem_addr, go to WAIT.
- WAIT: q_rst=0.
  - An armed flag sets once q_ok is sampled low.
  - Capture q_data into a register on the first posedge where armed=1 and q_ok=1, then go to CLAMP.
  - A stale high q_ok is never captured.
- CLAMP: compute s = sext10(q_data) + sext10(ZERO_POINT). lo = RELU ? ZERO_POINT : ACT_MIN. v = min(max(s, lo), ACT_MAX). Register v[7:0].
- PACK:
  - Write the byte into lane elem_cnt[1:0] of the pack register and set the matching bit in the lane mask.
  - Increment elem_cnt.
  - If lane==3 or elem_cnt+1==NUM_OUT, go to WRITE; else go to RESTART.
- WRITE: mem_we=1 for exactly one cycle; mem_wdata = pack register (unfilled lanes 0); mem_be = lane mask. Next cycle: mem_addr+1, pack register and mask cleared.
  - If all NUM_OUT elements are done, go to DONE; else go to RESTART.
- RESTART: q_rst=1 for exactly one cycle; armed cleared; go to WAIT.
- DONE: q_rst=1, done=1. start returns to WAIT with counters cleared.
- start is ignored while busy.
- Latency from the capturing edge in WAIT: CLAMP +1, PACK +2, mem_we +3.
- Simultaneous events: q_ok rising in the same cycle armed is set is not captured; capture occurs on the next cycle it is still high.
- mem_addr never exceeds ceil(NUM_OUT/4)-1. No wrap.

Test Plan:
- NUM_OUT=4, RELU=0, ZP=0; q_data 5, -3, 130(sat), 127 -> one write: addr 0, wdata 0x7F7FFD05, be 0xF; done=1; 4 q_rst pulses (3 RESTART + DONE level).
- Same stimulus with RELU=1 -> wdata 0x7F7F0005.
- ZP=10, RELU=0; q_data 120, -200, -138, 0 -> wdata 0x0A80807F.
- NUM_OUT=6, six values of 1 -> writes at addr 0 (be 0xF, 0x01010101) and addr 1 (be 0x3, wdata 0x00000101); no third write.
- q_ok held high across RESTART and into WAIT for 3 cycles, then low, then high with q_data=7 -> exactly one capture; byte 0x07 lands in the next lane.
- rst asserted after 2 elements captured -> all outputs at reset values, no write; a new start packs into addr 0 from lane 0.
